// File: rtl/uart_tx_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Bundle of requester and TX-core signals around the UART TX
//               arbiter.
//               slave  - the arbiter's view: it samples the requesters and
//                        tx_busy, and drives grants and the TX launch.
//               master - the environment's view: the requesters and the TX
//                        core together.
// Signals     : req_valid      [NUM_REQ]    byte pending per requester (level)
//               req_data       [8*NUM_REQ]  byte i at [8*i+7:8*i]
//               req_parity     [2*NUM_REQ]  0 none, 1 odd, 2 even, 3 none
//               req_ready      [NUM_REQ]    one-cycle accept pulse
//               tx_start                    one-cycle launch pulse
//               tx_data        [8]          byte held for the whole frame
//               tx_parity_type [2]          parity held for the whole frame
//               tx_busy                     TX core is sending a frame
//               grant_id       [IDW]        last/current granted requester
//               arb_busy                    arbiter is not idle
//               timeout_err                 one-cycle pulse, tx_busy never rose
// Revision    : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int C_IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [2*NUM_REQ-1:0] req_parity;
   logic [NUM_REQ-1:0]   req_ready;
   logic                 tx_start;
   logic [7:0]           tx_data;
   logic [1:0]           tx_parity_type;
   logic                 tx_busy;
   logic [C_IDW-1:0]     grant_id;
   logic                 arb_busy;
   logic                 timeout_err;

   // Environment side: requesters plus the TX core.
   modport master (
      output req_valid, req_data, req_parity, tx_busy,
      input  req_ready, tx_start, tx_data, tx_parity_type,
             grant_id, arb_busy, timeout_err
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_data, req_parity, tx_busy,
      output req_ready, tx_start, tx_data, tx_parity_type,
             grant_id, arb_busy, timeout_err
   );
endinterface

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Shares one parity-capable UART transmitter among NUM_REQ byte
//               requesters with round-robin arbitration. Each grant latches
//               one byte plus its parity mode, launches a TX frame, waits for
//               the TX core to raise and then drop tx_busy, and optionally
//               idles GAP_CLKS clocks before the next grant.
// Parameters  : NUM_REQ      number of requesters (>= 2)
//               GAP_CLKS     idle clocks after each frame (0 = none)
//               ACK_TIMEOUT  clocks allowed for tx_busy to rise (>= 1)
// Ports       : clk   system clock
//               rst   synchronous active-high reset
//               bus   uart_tx_arbiter_if.slave
//                       in : req_valid, req_data, req_parity, tx_busy
//                       out: req_ready, tx_start, tx_data, tx_parity_type,
//                            grant_id, arb_busy, timeout_err
//               Every output is registered.
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int NUM_REQ     = 4,
   parameter int GAP_CLKS    = 0,
   parameter int ACK_TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst,
   uart_tx_arbiter_if.slave bus
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int C_IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int C_CNT_MAX = (ACK_TIMEOUT > GAP_CLKS) ? ACK_TIMEOUT : GAP_CLKS;
   localparam int C_CW      = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX + 1) : 1;

   localparam logic [C_IDW:0]     C_ONE_W  = (C_IDW+1)'(1);
   localparam logic [C_IDW:0]     C_NREQ_W = (C_IDW+1)'(NUM_REQ);
   localparam logic [C_IDW-1:0]   C_PTR_RST = C_IDW'(NUM_REQ - 1);
   localparam logic [NUM_REQ-1:0] C_ONEHOT0 = NUM_REQ'(1);
   localparam logic [C_CW-1:0]    C_CNT_ONE = C_CW'(1);
   localparam logic [C_CW-1:0]    C_ACK_LAST = C_CW'(ACK_TIMEOUT - 1);
   localparam logic [C_CW-1:0]    C_GAP_LAST = (GAP_CLKS > 0) ? C_CW'(GAP_CLKS - 1) : '0;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LAUNCH    = 3'd1,
      S_WAIT_ACK  = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_GAP       = 3'd4
   } state_t;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   state_t             r_state;
   logic [C_IDW-1:0]   r_ptr;
   logic [C_CW-1:0]    r_cnt;
   logic [NUM_REQ-1:0] r_req_ready;
   logic               r_tx_start;
   logic [7:0]         r_tx_data;
   logic [1:0]         r_tx_par;
   logic [C_IDW-1:0]   r_grant_id;
   logic               r_arb_busy;
   logic               r_timeout_err;

   // ------------------------------------------------------------------------
   // Next-state values
   // ------------------------------------------------------------------------
   state_t             w_state_nx;
   state_t             w_post_state;
   logic [C_IDW-1:0]   w_ptr_nx;
   logic [C_CW-1:0]    w_cnt_nx;
   logic [NUM_REQ-1:0] w_req_ready_nx;
   logic               w_tx_start_nx;
   logic [7:0]         w_tx_data_nx;
   logic [1:0]         w_tx_par_nx;
   logic [C_IDW-1:0]   w_grant_id_nx;
   logic               w_timeout_err_nx;

   // ------------------------------------------------------------------------
   // Round-robin winner selection
   //
   // The request vector is rotated so that bit 0 is requester ptr+1; the
   // lowest set bit of the rotated vector is then the offset of the winner
   // from ptr+1. Rotation uses a double-width copy shifted right, so the
   // shift amount ptr+1 may equal NUM_REQ (pointer wrap to requester 0).
   // ------------------------------------------------------------------------
   logic [2*NUM_REQ-1:0] w_dbl_valid;
   logic [2*NUM_REQ-1:0] w_rot_full;
   logic [NUM_REQ-1:0]   w_rot;
   logic [C_IDW:0]       w_shift;
   logic [C_IDW:0]       w_sum;
   logic [C_IDW:0]       w_wrap;
   logic [C_IDW-1:0]     w_off;
   logic [C_IDW-1:0]     w_win;
   logic                 w_any;
   logic [7:0]           w_sel_data;
   logic [1:0]           w_sel_par_raw;
   logic [1:0]           w_sel_par;

   always_comb begin
      w_dbl_valid = {bus.req_valid, bus.req_valid};
      w_shift     = {1'b0, r_ptr} + C_ONE_W;
      w_rot_full  = w_dbl_valid >> w_shift;
      w_rot       = w_rot_full[NUM_REQ-1:0];
      w_any       = |w_rot;

      // Descending scan: the lowest set bit is the last one written.
      w_off = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (w_rot[i]) begin
            w_off = C_IDW'(i);
         end
      end

      // Winner = (ptr + 1 + offset) mod NUM_REQ; the sum stays below
      // 2*NUM_REQ so one conditional subtract is enough.
      w_sum  = {1'b0, r_ptr} + C_ONE_W + {1'b0, w_off};
      w_wrap = (w_sum >= C_NREQ_W) ? (w_sum - C_NREQ_W) : w_sum;
      w_win  = w_wrap[C_IDW-1:0];

      w_sel_data    = '0;
      w_sel_par_raw = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (w_win == C_IDW'(i)) begin
            w_sel_data    = bus.req_data[8*i +: 8];
            w_sel_par_raw = bus.req_parity[2*i +: 2];
         end
      end

      // Parity code 3 also means "none"; the TX core only ever sees 0/1/2.
      w_sel_par = (w_sel_par_raw == 2'd3) ? 2'd0 : w_sel_par_raw;
   end

   // ------------------------------------------------------------------------
   // FSM next-state and output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nx       = r_state;
      w_ptr_nx         = r_ptr;
      w_cnt_nx         = r_cnt;
      w_req_ready_nx   = '0;
      w_tx_start_nx    = 1'b0;
      w_tx_data_nx     = r_tx_data;
      w_tx_par_nx      = r_tx_par;
      w_grant_id_nx    = r_grant_id;
      w_timeout_err_nx = 1'b0;

      // With no gap configured a finished frame returns straight to IDLE.
      w_post_state = (GAP_CLKS == 0) ? S_IDLE : S_GAP;

      case (r_state)
         S_IDLE: begin
            // Requester inputs are only looked at here; data and parity are
            // captured in the same cycle as the grant.
            if (w_any) begin
               w_req_ready_nx = C_ONEHOT0 << w_win;
               w_tx_data_nx   = w_sel_data;
               w_tx_par_nx    = w_sel_par;
               w_grant_id_nx  = w_win;
               w_ptr_nx       = w_win;
               w_state_nx     = S_LAUNCH;
            end
         end

         S_LAUNCH: begin
            // Registered launch: the pulse is seen by the TX core during the
            // first WAIT_ACK cycle, one clock after req_ready.
            w_tx_start_nx = 1'b1;
            w_cnt_nx      = '0;
            w_state_nx    = S_WAIT_ACK;
         end

         S_WAIT_ACK: begin
            if (bus.tx_busy) begin
               w_state_nx = S_WAIT_DONE;
            end else if (r_cnt == C_ACK_LAST) begin
               w_timeout_err_nx = 1'b1;
               w_cnt_nx         = '0;
               w_state_nx       = w_post_state;
            end else begin
               w_cnt_nx = r_cnt + C_CNT_ONE;
            end
         end

         S_WAIT_DONE: begin
            if (!bus.tx_busy) begin
               w_cnt_nx   = '0;
               w_state_nx = w_post_state;
            end
         end

         S_GAP: begin
            if ((GAP_CLKS <= 1) || (r_cnt == C_GAP_LAST)) begin
               w_cnt_nx   = '0;
               w_state_nx = S_IDLE;
            end else begin
               w_cnt_nx = r_cnt + C_CNT_ONE;
            end
         end

         default: begin
            w_cnt_nx   = '0;
            w_state_nx = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         // Abandons any frame in flight; the TX core is not told.
         r_state       <= S_IDLE;
         r_ptr         <= C_PTR_RST;   // requester 0 searched first
         r_cnt         <= '0;
         r_req_ready   <= '0;
         r_tx_start    <= 1'b0;
         r_tx_data     <= '0;
         r_tx_par      <= '0;
         r_grant_id    <= '0;
         r_arb_busy    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state_nx;
         r_ptr         <= w_ptr_nx;
         r_cnt         <= w_cnt_nx;
         r_req_ready   <= w_req_ready_nx;
         r_tx_start    <= w_tx_start_nx;
         r_tx_data     <= w_tx_data_nx;
         r_tx_par      <= w_tx_par_nx;
         r_grant_id    <= w_grant_id_nx;
         // Registered from the next state so it tracks r_state exactly.
         r_arb_busy    <= (w_state_nx != S_IDLE);
         r_timeout_err <= w_timeout_err_nx;
      end
   end

   // ------------------------------------------------------------------------
   // Output drive
   // ------------------------------------------------------------------------
   assign bus.req_ready      = r_req_ready;
   assign bus.tx_start       = r_tx_start;
   assign bus.tx_data        = r_tx_data;
   assign bus.tx_parity_type = r_tx_par;
   assign bus.grant_id       = r_grant_id;
   assign bus.arb_busy       = r_arb_busy;
   assign bus.timeout_err    = r_timeout_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter (NUM_REQ=4,
//               GAP_CLKS=10, ACK_TIMEOUT=16). A transaction-timed reference
//               model predicts, for every clock, the accept pulse, launch,
//               held byte/parity, grant id, busy flag and timeout pulse from
//               the arbitration rules; directed sequences plus a randomized
//               phase drive requesters, reset and a behavioural TX core.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;

   localparam int NUM_REQ     = 4;
   localparam int GAP_CLKS    = 10;
   localparam int ACK_TIMEOUT = 16;
   localparam int C_INF       = 32'h7fff_ffff;

   logic clk = 1'b0;
   logic rst = 1'b1;

   uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

   uart_tx_arbiter #(
      .NUM_REQ     (NUM_REQ),
      .GAP_CLKS    (GAP_CLKS),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int tx_mode = 0;   // 0 random TX core, 1 busy 20 clks, 2 never responds

   task automatic check_val(input string tag, input logic [31:0] got,
                            input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NUM_REQ-1:0] v, input int ptr);
      for (int k = 1; k <= NUM_REQ; k++) begin
         if (v[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
      end
      return -1;
   endfunction

   // ------------------------------------------------------------------------
   // Reference model (sampled on the falling edge)
   // ------------------------------------------------------------------------
   int                   cyc = 0;
   bit                   armed = 0;
   bit                   p_rst = 0;
   bit                   p_grant = 0;
   logic [NUM_REQ-1:0]   p_valid;
   logic [8*NUM_REQ-1:0] p_data;
   logic [2*NUM_REQ-1:0] p_par;
   int                   m_ptr, m_gid, win;
   logic [7:0]           m_data;
   logic [1:0]           m_par;
   logic [NUM_REQ-1:0]   exp_ready;
   int                   idle_from, start_cyc, timeout_cyc;
   bit                   in_ack, in_done;

   always @(negedge clk) begin
      cyc++;
      if (p_rst) begin
         armed       = 1;
         m_ptr       = NUM_REQ - 1;
         m_gid       = 0;
         m_data      = '0;
         m_par       = '0;
         idle_from   = cyc;
         start_cyc   = -1;
         timeout_cyc = -1;
         in_ack      = 0;
         in_done     = 0;
      end
      exp_ready = '0;
      if (armed) begin
         if (p_grant) begin
            win            = rr_pick(p_valid, m_ptr);
            exp_ready[win] = 1'b1;
            m_ptr          = win;
            m_gid          = win;
            m_data         = p_data[8*win +: 8];
            m_par          = (p_par[2*win +: 2] == 2'd3) ? 2'd0 : p_par[2*win +: 2];
            start_cyc      = cyc + 1;
            timeout_cyc    = -1;
            idle_from      = C_INF;
            in_ack         = 1;
            in_done        = 0;
         end
         check_val("ready",    32'(bus.req_ready),      32'(exp_ready));
         check_val("tx_start", 32'(bus.tx_start),       32'(cyc == start_cyc));
         check_val("tx_data",  32'(bus.tx_data),        32'(m_data));
         check_val("tx_par",   32'(bus.tx_parity_type), 32'(m_par));
         check_val("grant_id", 32'(bus.grant_id),       32'(m_gid));
         check_val("timeout",  32'(bus.timeout_err),    32'(cyc == timeout_cyc));
         check_val("arb_busy", 32'(bus.arb_busy),       32'(cyc < idle_from));

         // Frame progress from this cycle's tx_busy.
         if (in_ack && cyc >= start_cyc) begin
            if (bus.tx_busy) begin
               in_ack  = 0;
               in_done = 1;
            end else if (cyc == start_cyc + ACK_TIMEOUT - 1) begin
               in_ack      = 0;
               timeout_cyc = cyc + 1;
               idle_from   = cyc + 1 + GAP_CLKS;
            end
         end else if (in_done && !bus.tx_busy) begin
            in_done   = 0;
            idle_from = cyc + 1 + GAP_CLKS;
         end
      end
      p_grant = armed && !rst && (cyc >= idle_from) && (|bus.req_valid);
      p_valid = bus.req_valid;
      p_data  = bus.req_data;
      p_par   = bus.req_parity;
      p_rst   = rst;
   end

   // ------------------------------------------------------------------------
   // Behavioural TX core
   // ------------------------------------------------------------------------
   initial begin : tx_core
      int d, len;
      bus.tx_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (bus.tx_start === 1'b1 && !rst) begin
            if (tx_mode == 2 || (tx_mode == 0 && $urandom_range(0, 4) == 0)) begin
               d = 0;   // no response: arbiter must time out
            end else begin
               d   = (tx_mode == 1) ? 1  : int'($urandom_range(1, 6));
               len = (tx_mode == 1) ? 20 : int'($urandom_range(1, 12));
               repeat (d) @(posedge clk);
               #1 bus.tx_busy = 1'b1;
               repeat (len) @(posedge clk);
               #1 bus.tx_busy = 1'b0;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Bounded waits
   // ------------------------------------------------------------------------
   task automatic wait_ready(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(|bus.req_ready) && n < budget);
      check_val(tag, 32'(|bus.req_ready), 32'd1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.arb_busy && n < budget);
      check_val(tag, 32'(bus.arb_busy), 32'd0);
   endtask

   task automatic wait_busy(input string tag, input logic lvl, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.tx_busy !== lvl && n < budget);
      check_val(tag, 32'(bus.tx_busy), 32'(lvl));
   endtask

   task automatic pulse_rst();
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   initial begin : main
      int n;
      bus.req_valid  = '0;
      bus.req_data   = '0;
      bus.req_parity = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      // Single requester, even parity.
      bus.req_data[7:0]   = 8'h55;
      bus.req_parity[1:0] = 2'd2;
      bus.req_valid       = 4'b0001;
      wait_ready("t1_wait_ready", 20);
      check_val("t1_ready", 32'(bus.req_ready), 32'h1);
      @(negedge clk);
      check_val("t1_start", 32'(bus.tx_start), 32'd1);
      check_val("t1_data",  32'(bus.tx_data), 32'h55);
      check_val("t1_par",   32'(bus.tx_parity_type), 32'd2);
      bus.req_valid = '0;
      wait_idle("t1_idle", 300);
      check_val("t1_hold", 32'(bus.tx_data), 32'h55);

      // Parity code 3 presented as 0.
      @(posedge clk); #1;
      bus.req_data[23:16]  = 8'hA3;
      bus.req_parity[5:4]  = 2'd3;
      bus.req_valid        = 4'b0100;
      wait_ready("t3_wait_ready", 20);
      check_val("t3_par",  32'(bus.tx_parity_type), 32'd0);
      check_val("t3_data", 32'(bus.tx_data), 32'hA3);
      bus.req_valid = '0;
      wait_idle("t3_idle", 300);

      // Acknowledge timeout, then a normal grant.
      tx_mode = 2;
      @(posedge clk); #1 bus.req_valid = 4'b0010;
      wait_ready("t4_wait_ready", 20);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.timeout_err && n < 40);
      check_val("t4_timeout_lat", 32'(n), 32'd17);
      bus.req_valid = '0;
      tx_mode = 1;
      wait_idle("t4_idle", 100);
      @(posedge clk); #1 bus.req_valid = 4'b1000;
      wait_ready("t4_next_ready", 20);
      check_val("t4_next_gid", 32'(bus.grant_id), 32'd3);
      bus.req_valid = '0;
      wait_idle("t4_next_idle", 300);

      // Inter-frame gap; input churn during the frame.
      @(posedge clk); #1 bus.req_valid = 4'b1111;
      wait_ready("t5_wait_ready", 20);
      wait_busy("t5_busy_rise", 1'b1, 20);
      n = 0;
      do begin
         @(negedge clk);
         bus.req_data   = $urandom;
         bus.req_parity = 8'($urandom);
         n++;
      end while (bus.tx_busy && n < 40);
      check_val("t5_busy_fall", 32'(bus.tx_busy), 32'd0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.tx_start && n < 40);
      check_val("t5_spacing_ge12", 32'(n >= 12), 32'd1);
      bus.req_valid = '0;
      wait_idle("t5_idle", 300);

      // Reset during WAIT_DONE.
      @(posedge clk); #1 bus.req_valid = 4'b0100;
      wait_ready("t6_wait_ready", 20);
      wait_busy("t6_busy_rise", 1'b1, 20);
      @(negedge clk);
      bus.req_valid = 4'b1111;
      pulse_rst();
      @(negedge clk);
      check_val("t6_arb_busy", 32'(bus.arb_busy), 32'd0);
      check_val("t6_data",     32'(bus.tx_data), 32'd0);
      check_val("t6_gid",      32'(bus.grant_id), 32'd0);
      check_val("t6_ready",    32'(bus.req_ready), 32'd0);
      wait_ready("t6_wait_ready2", 20);
      check_val("t6_winner", 32'(bus.req_ready), 32'h1);
      bus.req_valid = '0;
      wait_idle("t6_idle", 300);

      // Fairness with every requester pending.
      pulse_rst();
      bus.req_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         wait_ready("t2_wait_ready", 200);
         check_val("t2_gid",    32'(bus.grant_id), 32'(i % NUM_REQ));
         check_val("t2_onehot", 32'($countones(bus.req_ready)), 32'd1);
      end
      bus.req_valid = '0;
      wait_idle("t2_idle", 300);

      // Randomized traffic including occasional resets.
      tx_mode = 0;
      for (int i = 0; i < 4000; i++) begin
         @(posedge clk); #1;
         if ($urandom_range(0, 3) == 0) bus.req_valid = NUM_REQ'($urandom);
         bus.req_data   = $urandom;
         bus.req_parity = 8'($urandom);
         rst            = ($urandom_range(0, 599) == 0);
      end
      @(posedge clk); #1;
      rst           = 1'b0;
      bus.req_valid = '0;
      wait_idle("final_idle", 300);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
      $fatal(1);
   end

endmodule

`default_nettype wire
